// File: rtl/rv_bus_arb_pkg.sv
// Shared state encoding and constants for the fetch/LSU memory bus arbiter.
package rv_bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IF,
    ARB_LS,
    ARB_IF_KILL
  } arb_state_t;

  localparam logic [3:0] IF_BE_ALL = 4'hF;

endpackage

// File: rtl/rv_bus_arb_starve_cnt.sv
// Counts back-to-back LS grants taken while fetch waits; flags when fetch must win.
// Single-cycle update on grant; compare is combinational against STARVE_LIMIT.
module rv_bus_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req,
  input  logic ls_grant,
  input  logic if_grant,
  output logic force_if
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (if_grant || (idle && !if_req)) begin
      cnt <= '0;
    end else if (ls_grant && if_req && (cnt != 4'hF)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign force_if = (cnt == 4'(STARVE_LIMIT));

endmodule

// File: rtl/rv_bus_arbiter.sv
// Shares one memory bus between fetch and LSU; LS priority, optional fairness via RV_BUS_ARB_STARVE_GUARD_EN.
// Grant registered one cycle after request; owner ack is combinational with bus ack; requesters stall until ack.
module rv_bus_arbiter
  import rv_bus_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:2] i_if_addr,
  input  logic        i_if_kill,
  output logic        o_if_ack,
  output logic [31:0] o_if_rdata,
  output logic        o_if_stall,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:2] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_be,
  output logic        o_ls_ack,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:2] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  arb_state_t state, state_nxt;
  logic       grant_if;
  logic       grant_ls;
  logic       force_if;

`ifdef RV_BUS_ARB_STARVE_GUARD_EN
  rv_bus_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (i_clk),
    .rst      (i_reset),
    .idle     (state == ARB_IDLE),
    .if_req   (i_if_req),
    .ls_grant (grant_ls),
    .if_grant (grant_if),
    .force_if (force_if)
  );
`else
  logic unused_cfg;
  assign force_if   = 1'b0;
  assign unused_cfg = ^4'(STARVE_LIMIT);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    o_if_ack  = 1'b0;
    o_ls_ack  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (i_ls_req && !(force_if && i_if_req)) begin
          grant_ls  = 1'b1;
          state_nxt = ARB_LS;
        end else if (i_if_req) begin
          grant_if  = 1'b1;
          state_nxt = ARB_IF;
        end
      end
      ARB_IF: begin
        // A redirect in the ack cycle drops the stale fetch data outright.
        if (i_bus_ack) begin
          o_if_ack  = !i_if_kill;
          state_nxt = ARB_IDLE;
        end else if (i_if_kill) begin
          state_nxt = ARB_IF_KILL;
        end
      end
      ARB_LS: begin
        if (i_bus_ack) begin
          o_ls_ack  = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      ARB_IF_KILL: begin
        if (i_bus_ack) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Grants only happen in IDLE, so the payload is frozen for the whole transaction.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_be    <= '0;
    end else if (grant_ls) begin
      o_bus_req   <= 1'b1;
      o_bus_we    <= i_ls_we;
      o_bus_addr  <= i_ls_addr;
      o_bus_wdata <= i_ls_wdata;
      o_bus_be    <= i_ls_be;
    end else if (grant_if) begin
      o_bus_req   <= 1'b1;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= i_if_addr;
      o_bus_wdata <= '0;
      o_bus_be    <= IF_BE_ALL;
    end else if (i_bus_ack && (state != ARB_IDLE)) begin
      o_bus_req   <= 1'b0;
    end
  end

  assign o_if_rdata = o_if_ack ? i_bus_rdata : '0;
  assign o_ls_rdata = o_ls_ack ? i_bus_rdata : '0;
  assign o_if_stall = i_if_req & !o_if_ack;
  assign o_ls_stall = i_ls_req & !o_ls_ack;

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Directed vector bench for rv_bus_arbiter: per-cycle table plus reset and starvation sequences.
module tb_rv_bus_arbiter;
  import rv_bus_arb_pkg::*;

  localparam logic        Y  = 1'b1;
  localparam logic        N  = 1'b0;
  localparam logic [29:0] A0 = 30'h0;
  localparam logic [31:0] D0 = 32'h0;
  localparam logic [3:0]  BF = 4'hF;
  localparam int          NV = 30;

  typedef struct packed {
    logic        ifr;
    logic [29:0] ifa;
    logic        kill;
    logic        lsr;
    logic        we;
    logic [29:0] lsa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        breq;
    logic        ifack;
    logic [31:0] ifrd;
    logic        lsack;
    logic [31:0] lsrd;
    logic        ifst;
    logic        lsst;
    arb_state_t  st;
    logic        pay;
    logic [29:0] addr;
    logic        bwe;
    logic [31:0] bwd;
    logic [3:0]  bbe;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        i_clk, i_reset;
  logic        i_if_req, i_if_kill, i_ls_req, i_ls_we, i_bus_ack;
  logic [31:2] i_if_addr, i_ls_addr;
  logic [31:0] i_ls_wdata, i_bus_rdata;
  logic [3:0]  i_ls_be;
  logic        o_if_ack, o_if_stall, o_ls_ack, o_ls_stall, o_bus_req, o_bus_we;
  logic [31:0] o_if_rdata, o_ls_rdata, o_bus_wdata;
  logic [31:2] o_bus_addr;
  logic [3:0]  o_bus_be;

  int   n_pass = 0;
  int   n_total = 0;
  int   row = -1;
  vec_t vecs[NV];

  rv_bus_arbiter #(.STARVE_LIMIT(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_kill(i_if_kill),
    .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata), .o_if_stall(o_if_stall),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_be(i_ls_be),
    .o_ls_ack(o_ls_ack), .o_ls_rdata(o_ls_rdata), .o_ls_stall(o_ls_stall),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
    .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s row %0d: got %b want %b", name, row, act, exp);
    else n_pass++;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    else n_pass++;
  endtask

  function automatic in_t mi(logic ifr, logic [29:0] ifa, logic kill, logic lsr, logic we,
                             logic [29:0] lsa, logic [31:0] wd, logic [3:0] be,
                             logic ack, logic [31:0] rd);
    return '{ifr, ifa, kill, lsr, we, lsa, wd, be, ack, rd};
  endfunction

  function automatic in_t ifv(logic ifr, logic [29:0] a, logic kill, logic ack, logic [31:0] rd);
    return mi(ifr, a, kill, N, N, A0, D0, 4'h0, ack, rd);
  endfunction

  function automatic in_t lsv(logic we, logic [29:0] a, logic [31:0] wd, logic [3:0] be,
                              logic kill, logic ack, logic [31:0] rd);
    return mi(N, A0, kill, Y, we, a, wd, be, ack, rd);
  endfunction

  function automatic exp_t eidle(logic ifst, logic lsst);
    return '{N, N, D0, N, D0, ifst, lsst, ARB_IDLE, N, A0, N, D0, 4'h0};
  endfunction

  function automatic exp_t ebus(arb_state_t st, logic ifack, logic [31:0] ifrd, logic lsack,
                                logic [31:0] lsrd, logic ifst, logic lsst, logic [29:0] addr,
                                logic bwe, logic [31:0] bwd, logic [3:0] bbe);
    return '{Y, ifack, ifrd, lsack, lsrd, ifst, lsst, st, Y, addr, bwe, bwd, bbe};
  endfunction

  task automatic drive(input in_t v);
    i_if_req    = v.ifr;
    i_if_addr   = v.ifa;
    i_if_kill   = v.kill;
    i_ls_req    = v.lsr;
    i_ls_we     = v.we;
    i_ls_addr   = v.lsa;
    i_ls_wdata  = v.wd;
    i_ls_be     = v.be;
    i_bus_ack   = v.ack;
    i_bus_rdata = v.rd;
  endtask

  task automatic check_row(input exp_t e);
    chk1 ("bus_req",  o_bus_req,  e.breq);
    chk1 ("if_ack",   o_if_ack,   e.ifack);
    chk32("if_rdata", o_if_rdata, e.ifrd);
    chk1 ("ls_ack",   o_ls_ack,   e.lsack);
    chk32("ls_rdata", o_ls_rdata, e.lsrd);
    chk1 ("if_stall", o_if_stall, e.ifst);
    chk1 ("ls_stall", o_ls_stall, e.lsst);
    chk32("state",    {30'b0, dut.state}, {30'b0, e.st});
    if (e.pay) begin
      chk32("bus_addr",  {o_bus_addr, 2'b00}, {e.addr, 2'b00});
      chk1 ("bus_we",    o_bus_we, e.bwe);
      chk32("bus_wdata", o_bus_wdata, e.bwd);
      chk32("bus_be",    {28'b0, o_bus_be}, {28'b0, e.bbe});
    end
  endtask

  logic gw[$];
  logic [5:0] exp_order;
  logic stall_all;

  initial begin
    // single fetch, ack two cycles after bus_req
    vecs[0]  = '{ifv(Y, 30'h40, N, N, D0), eidle(Y, N)};
    vecs[1]  = '{ifv(Y, 30'h40, N, N, D0), ebus(ARB_IF, N, D0, N, D0, Y, N, 30'h40, N, D0, BF)};
    vecs[2]  = '{ifv(Y, 30'h40, N, N, D0), ebus(ARB_IF, N, D0, N, D0, Y, N, 30'h40, N, D0, BF)};
    vecs[3]  = '{ifv(Y, 30'h40, N, Y, 32'h13), ebus(ARB_IF, Y, 32'h13, N, D0, N, N, 30'h40, N, D0, BF)};
    vecs[4]  = '{ifv(N, A0, N, N, D0), eidle(N, N)};
    // simultaneous requests: LS write first, then IF
    vecs[5]  = '{mi(Y, 30'h44, N, Y, Y, 30'h100, 32'hDEADBEEF, 4'h3, N, D0), eidle(Y, Y)};
    vecs[6]  = '{mi(Y, 30'h44, N, Y, Y, 30'h100, 32'hDEADBEEF, 4'h3, N, D0),
                 ebus(ARB_LS, N, D0, N, D0, Y, Y, 30'h100, Y, 32'hDEADBEEF, 4'h3)};
    vecs[7]  = '{mi(Y, 30'h44, N, Y, Y, 30'h100, 32'hDEADBEEF, 4'h3, Y, 32'h55),
                 ebus(ARB_LS, N, D0, Y, 32'h55, Y, N, 30'h100, Y, 32'hDEADBEEF, 4'h3)};
    vecs[8]  = '{ifv(Y, 30'h44, N, N, D0), eidle(Y, N)};
    vecs[9]  = '{ifv(Y, 30'h44, N, N, D0), ebus(ARB_IF, N, D0, N, D0, Y, N, 30'h44, N, D0, BF)};
    vecs[10] = '{ifv(Y, 30'h44, N, Y, 32'h77), ebus(ARB_IF, Y, 32'h77, N, D0, N, N, 30'h44, N, D0, BF)};
    vecs[11] = '{ifv(N, A0, N, N, D0), eidle(N, N)};
    // spurious ack in IDLE
    vecs[12] = '{ifv(N, A0, N, Y, 32'hFFFFFFFF), eidle(N, N)};
    vecs[13] = '{ifv(N, A0, N, N, D0), eidle(N, N)};
    // kill one cycle after grant, ack three cycles later, then redirected fetch
    vecs[14] = '{ifv(Y, 30'h80, N, N, D0), eidle(Y, N)};
    vecs[15] = '{ifv(Y, 30'h80, Y, N, D0), ebus(ARB_IF, N, D0, N, D0, Y, N, 30'h80, N, D0, BF)};
    vecs[16] = '{ifv(Y, 30'hC0, N, N, D0), ebus(ARB_IF_KILL, N, D0, N, D0, Y, N, 30'h80, N, D0, BF)};
    vecs[17] = '{ifv(Y, 30'hC0, N, N, D0), ebus(ARB_IF_KILL, N, D0, N, D0, Y, N, 30'h80, N, D0, BF)};
    vecs[18] = '{ifv(Y, 30'hC0, N, Y, 32'h1234), ebus(ARB_IF_KILL, N, D0, N, D0, Y, N, 30'h80, N, D0, BF)};
    vecs[19] = '{ifv(Y, 30'hC0, N, N, D0), eidle(Y, N)};
    vecs[20] = '{ifv(Y, 30'hC0, N, N, D0), ebus(ARB_IF, N, D0, N, D0, Y, N, 30'hC0, N, D0, BF)};
    vecs[21] = '{ifv(Y, 30'hC0, N, Y, 32'h99), ebus(ARB_IF, Y, 32'h99, N, D0, N, N, 30'hC0, N, D0, BF)};
    vecs[22] = '{ifv(N, A0, N, N, D0), eidle(N, N)};
    // kill and ack in the same cycle
    vecs[23] = '{ifv(Y, 30'h10, N, N, D0), eidle(Y, N)};
    vecs[24] = '{ifv(Y, 30'h10, Y, Y, 32'h5), ebus(ARB_IF, N, D0, N, D0, Y, N, 30'h10, N, D0, BF)};
    vecs[25] = '{ifv(N, A0, N, N, D0), eidle(N, N)};
    // kill ignored while LS owns the bus
    vecs[26] = '{lsv(N, 30'h20, D0, BF, Y, N, D0), eidle(N, Y)};
    vecs[27] = '{lsv(N, 30'h20, D0, BF, Y, N, D0), ebus(ARB_LS, N, D0, N, D0, N, Y, 30'h20, N, D0, BF)};
    vecs[28] = '{lsv(N, 30'h20, D0, BF, Y, Y, 32'hABCD),
                 ebus(ARB_LS, N, D0, Y, 32'hABCD, N, N, 30'h20, N, D0, BF)};
    vecs[29] = '{ifv(N, A0, N, N, D0), eidle(N, N)};

    drive(ifv(N, A0, N, N, D0));
    i_reset = 1'b0;
    #1 i_reset = 1'b1;
    #12;
    chk1 ("rst_bus_req",   o_bus_req, N);
    chk1 ("rst_bus_we",    o_bus_we,  N);
    chk32("rst_bus_addr",  {o_bus_addr, 2'b00}, D0);
    chk32("rst_bus_wdata", o_bus_wdata, D0);
    chk32("rst_bus_be",    {28'b0, o_bus_be}, D0);
    chk1 ("rst_if_ack",    o_if_ack, N);
    chk1 ("rst_ls_ack",    o_ls_ack, N);
    chk32("rst_state",     {30'b0, dut.state}, {30'b0, ARB_IDLE});
    @(posedge i_clk); #1 i_reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(posedge i_clk); #1;
      drive(vecs[k].i);
      @(negedge i_clk);
      row = k;
      check_row(vecs[k].e);
    end

    // asynchronous reset in the middle of an LS transaction
    row = 100;
    @(posedge i_clk); #1;
    drive(lsv(Y, 30'h200, 32'h1, BF, N, N, D0));
    @(posedge i_clk); #1;
    chk1("arst_pre_bus_req", o_bus_req, Y);
    #2;
    i_bus_ack   = 1'b1;
    i_bus_rdata = 32'hCAFE;
    i_reset     = 1'b1;
    #1;
    chk1 ("arst_bus_req",  o_bus_req, N);
    chk1 ("arst_ls_ack",   o_ls_ack,  N);
    chk32("arst_ls_rdata", o_ls_rdata, D0);
    chk32("arst_state",    {30'b0, dut.state}, {30'b0, ARB_IDLE});
    chk32("arst_bus_addr", {o_bus_addr, 2'b00}, D0);
    drive(ifv(N, A0, N, N, D0));
    @(posedge i_clk); #1 i_reset = 1'b0;

    // both requesters held continuously, bus acks every transaction immediately
    row = 200;
    stall_all = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge i_clk); #1;
      drive(mi(Y, 30'h300, N, Y, Y, 30'h310, 32'h1111, BF, o_bus_req, 32'h2222));
      if (o_bus_req) gw.push_back(o_bus_we);
      @(negedge i_clk);
      if (!o_if_stall) stall_all = 1'b0;
    end
    drive(ifv(N, A0, N, N, D0));
`ifdef RV_BUS_ARB_STARVE_GUARD_EN
    exp_order = 6'b011011;
`else
    exp_order = 6'b111111;
    chk1("if_stall_const", stall_all, Y);
`endif
    chk32("grant_count", gw.size(), 32'd6);
    for (int g = 0; g < 6; g++) begin
      row = 200 + g;
      if (g < gw.size()) chk1("grant_is_ls", gw[g], exp_order[g]);
    end

    repeat (2) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rv_bus_arbiter.md
# rv_bus_arbiter

Shares the core's single memory bus between the instruction-fetch stage and the load/store stage. It accepts one request per side, grants the bus to one owner at a time, and holds the bus request and payload stable until the bus acknowledges. It returns the acknowledge and read data to the owner and drives stall signals back into the pipeline; fetch uses the fetch stall as its pre-stall. It sits between the fetch/LSU stages and the external memory bus.

## Interface
- STARVE_LIMIT, 4: consecutive LS grants allowed while IF waits (guard build only); legal range 1..15.
- i_clk  in  1  core clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_if_req  in  1  fetch request; held with i_if_addr stable until o_if_ack.
- i_if_addr  in  [31:2]  fetch word address.
- i_if_kill  in  1  fetch redirect; discards the in-flight fetch result.
- o_if_ack  out  1  fetch transaction complete, one-cycle pulse.
- o_if_rdata  out  32  fetch read data, valid with o_if_ack.
- o_if_stall  out  1  i_if_req & !o_if_ack.
- i_ls_req  in  1  load/store request; held with its payload until o_ls_ack.
- i_ls_we  in  1  1 = write.
- i_ls_addr  in  [31:2]  data word address.
- i_ls_wdata  in  32  write data.
- i_ls_be  in  4  byte enables.
- o_ls_ack  out  1  LS transaction complete, one-cycle pulse.
- o_ls_rdata  out  32  LS read data, valid with o_ls_ack.
- o_ls_stall  out  1  i_ls_req & !o_ls_ack.
- o_bus_req  out  1  bus request, registered.
- o_bus_we, o_bus_addr[31:2], o_bus_wdata[31:0], o_bus_be[3:0]  out  bus payload, registered at grant.
- i_bus_ack  in  1  bus completion.
- i_bus_rdata  in  32  bus read data, valid with i_bus_ack.

## Operation
- FSM states:
  - ARB_IDLE: no transaction active.
  - ARB_IF: fetch owns the bus.
  - ARB_LS: LS owns the bus.
  - ARB_IF_KILL: fetch transaction in flight; its result will be dropped.
- In ARB_IDLE, grant selection:
  - i_ls_req → ARB_LS.
  - Otherwise i_if_req → ARB_IF.
  - Otherwise stay in ARB_IDLE.
- On grant, the owner's payload is latched into the o_bus_* registers and o_bus_req goes to 1.
- For IF grants: o_bus_we=0, o_bus_be=4'hF, o_bus_wdata=0.
- o_bus_req stays 1 and the payload stays frozen until i_bus_ack.
- Completion in ARB_IF/ARB_LS:
  - i_bus_ack produces a combinational owner ack: o_X_ack=1 and o_X_rdata=i_bus_rdata in that same cycle.
  - Next state is ARB_IDLE; o_bus_req=0 in the next cycle.
- i_if_kill in ARB_IF, no ack that cycle: next state ARB_IF_KILL.
- i_if_kill and i_bus_ack in the same cycle: the ack is suppressed (o_if_ack=0) and the next state is ARB_IDLE.
- ARB_IF_KILL:
  - o_bus_req stays 1, since a bus transaction cannot be aborted.
  - o_if_ack is held 0; on i_bus_ack the next state is ARB_IDLE and the data is discarded.
- i_if_kill in any other state is ignored.
- i_bus_ack in ARB_IDLE is spurious: ignored, and no ack is forwarded.
- o_X_rdata is driven to 0 whenever o_X_ack=0.
- Requesters must drop or change their request in the cycle after their ack. The arbiter never re-grants in an ack cycle, which prevents a double-issue.

## Timing
- Reset values: state ARB_IDLE; o_bus_req=0; all o_bus_* payload=0; o_if_ack=o_ls_ack=0; guard counter=0.
- Reset mid-transaction: the transaction is abandoned and the arbiter returns to ARB_IDLE. Requesters reissue after reset.
- Grant latency: request seen in ARB_IDLE at cycle N → o_bus_req=1 at N+1.
- Ack latency: zero cycles from i_bus_ack to o_X_ack.
- Minimum spacing between bus transactions is 2 cycles: ack cycle, then IDLE decision cycle.
- Simultaneous i_if_req and i_ls_req in ARB_IDLE: LS wins, subject to the starvation guard.

## Configuration
- Macro: RV_BUS_ARB_STARVE_GUARD_EN.
- When defined:
  - A 4-bit counter increments on each LS grant made while i_if_req=1.
  - It clears on any IF grant, and whenever i_if_req=0 in ARB_IDLE.
  - When the counter equals STARVE_LIMIT and both requests are pending in ARB_IDLE, IF is granted.
- When undefined: strict LS priority; the counter and STARVE_LIMIT are unused.

## Structure
- Package rv_bus_arb_pkg holds:
  - typedef enum logic[1:0] arb_state_t {ARB_IDLE, ARB_IF, ARB_LS, ARB_IF_KILL};
  - localparam IF_BE_ALL = 4'hF.
- Optional sub-module rv_bus_arb_starve_cnt contains the guard counter and compare. It is instantiated only under RV_BUS_ARB_STARVE_GUARD_EN.

## Test plan
- Single fetch of i_if_addr=30'h40, bus acks 2 cycles after o_bus_req → o_bus_addr=30'h40, o_if_ack=1 with o_if_rdata=32'h00000013 on the ack cycle, o_bus_req=0 next cycle.
- i_if_req and i_ls_req (write, addr 30'h100, wdata 32'hDEADBEEF, be 4'h3) in the same cycle → LS granted first with o_bus_we=1, o_bus_be=4'h3; IF granted 2 cycles after LS ack.
- i_if_kill one cycle after an IF grant, bus acks 3 cycles later → state ARB_IF_KILL, o_if_ack never pulses, o_bus_req stays 1 until ack, then IDLE.
- Async i_reset mid-LS transaction → o_bus_req=0 and state ARB_IDLE immediately; no o_ls_ack.
- Spurious i_bus_ack in IDLE → no o_if_ack or o_ls_ack; state unchanged.
- Guard build, STARVE_LIMIT=2, continuous LS and IF requests → grant order LS, LS, IF, LS, LS, IF; non-guard build → LS only, o_if_stall constantly 1.
